// File: rtl/strat_order_sequencer_pkg.sv
// Shared types and constants for the strategy order sequencer.
package strat_order_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_COOLDOWN
  } state_e;

  typedef struct packed {
    logic        side;
    logic [31:0] price;
    logic [31:0] qty;
  } order_t;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  // Bits needed to hold 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/strat_order_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/strat_order_sequencer.sv
// Turns one-cycle strategy intents into handshaked orders, waits for an ack
// (or timeout), then enforces a cooldown gap before the next intent.
module strat_order_sequencer
  import strat_order_sequencer_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT     = 256,
  parameter bit          DEDUP_EN        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        strat_valid,
  input  logic        strat_side,
  input  logic [31:0] strat_price,
  input  logic [31:0] strat_qty,
  output logic        ord_valid,
  input  logic        ord_ready,
  output logic        ord_side,
  output logic [31:0] ord_price,
  output logic [31:0] ord_qty,
  input  logic        ack_valid,
  input  logic        ack_ok,
  output logic        busy,
  output logic        timeout_pulse,
  output logic [15:0] drop_count
);

  localparam int unsigned TW = cnt_width(ACK_TIMEOUT);
  localparam int unsigned CW = cnt_width(COOLDOWN_CYCLES);

  state_e        state_q, state_d;
  order_t        order_q, order_d;
  order_t        last_q, last_d;
  logic          last_valid_q, last_valid_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cool_q, cool_d;

  order_t intent;
  logic   is_dup, capture, drop, ack_expire, cool_done;

  assign intent     = '{side: strat_side, price: strat_price, qty: strat_qty};
  assign is_dup     = DEDUP_EN && last_valid_q && (intent == last_q);
  assign capture    = (state_q == ST_IDLE) && strat_valid && enable && !is_dup;
  assign drop       = strat_valid && !capture;
  assign ack_expire = (timer_q == TW'(ACK_TIMEOUT - 1));
  assign cool_done  = (cool_q == CW'(COOLDOWN_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      order_q      <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      timer_q      <= '0;
      cool_q       <= '0;
    end else begin
      state_q      <= state_d;
      order_q      <= order_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      timer_q      <= timer_d;
      cool_q       <= cool_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    order_d      = order_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    timer_d      = timer_q;
    cool_d       = cool_q;
    unique case (state_q)
      ST_IDLE: begin
        if (capture) begin
          order_d = intent;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ord_ready) begin
          state_d      = ST_WAIT_ACK;
          timer_d      = '0;
          last_d       = order_q;
          last_valid_d = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q + TW'(1);
        // An ack on the expiry cycle wins over the timeout.
        if (ack_valid || ack_expire) begin
          if (!ack_valid || !ack_ok) last_valid_d = 1'b0;
          cool_d  = '0;
          state_d = (COOLDOWN_CYCLES > 0) ? ST_COOLDOWN : ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        if (cool_done) state_d = ST_IDLE;
        else           cool_d  = cool_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ord_valid     = (state_q == ST_ISSUE);
    busy          = (state_q != ST_IDLE);
    timeout_pulse = (state_q == ST_WAIT_ACK) && ack_expire && !ack_valid;
  end

  assign ord_side  = order_q.side;
  assign ord_price = order_q.price;
  assign ord_qty   = order_q.qty;

  sat_counter #(
    .WIDTH(16)
  ) u_drop_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (drop),
    .count_o(drop_count)
  );

endmodule
